div_restoring_seq: RTL and testbench

Sequential restoring divider for the keypad calculator datapath. It sits downstream of the keypad operand-capture stage, which supplies the assembled 8-bit dividend and divisor plus a start strobe. It sits upstream of the 7-segment display driver, which consumes quotient, remainder and the done pulse. It produces one quotient bit per clock, using an iterative shift/subtract core with a start/busy/done handshake.

---
 rtl/div_restoring_seq.sv | 123 ++++++++++++
 tb/tb_div_restoring_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/div_restoring_seq.sv
`default_nettype none
// ============================================================================
// Module   : div_restoring_seq
// Brief    : Sequential unsigned restoring divider, one quotient bit per clock,
//            start/busy/done handshake. Optional macro: DIV_ZERO_SHORTCUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module div_restoring_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_zero
);

  localparam int c_cnt_w = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_dvd;
  logic [WIDTH-1:0]     r_dsr;
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     r_quo;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_dz;

  logic [WIDTH:0]       w_rem_sh;
  logic [WIDTH:0]       w_diff;
  logic                 w_ge;
  logic [WIDTH-1:0]     w_rem_nx;

  // Stored remainder is always < divisor, so it fits WIDTH bits; the shifted
  // trial value and the subtraction are WIDTH+1 wide, and the borrow (MSB of
  // the difference) is the restoring decision.
  always_comb begin
    w_rem_sh = {r_rem, r_dvd[WIDTH-1]};
    w_diff   = w_rem_sh - {1'b0, r_dsr};
    w_ge     = ~w_diff[WIDTH];
    w_rem_nx = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_dvd    <= '0;
      r_dsr    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_cnt    <= '0;
      r_dz     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      q        <= '0;
      r        <= '0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // busy is still high during the done cycle and stays high only if
          // a new request is taken on this same edge.
          busy <= start;
          if (start) begin
            r_dsr <= b_in;
            r_dz  <= (b_in == '0);
            r_cnt <= c_cnt_init;
`ifdef DIV_ZERO_SHORTCUT_EN
            if (b_in == '0) begin
              r_dvd   <= '0;
              r_quo   <= '1;
              r_rem   <= a_in;
              r_state <= S_DONE;
            end else begin
              r_dvd   <= a_in;
              r_quo   <= '0;
              r_rem   <= '0;
              r_state <= S_RUN;
            end
`else
            r_dvd   <= a_in;
            r_quo   <= '0;
            r_rem   <= '0;
            r_state <= S_RUN;
`endif
          end
        end
        S_RUN: begin
          r_rem <= w_rem_nx;
          r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
          r_quo <= {r_quo[WIDTH-2:0], w_ge};
          if (r_cnt == '0) begin
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          q        <= r_quo;
          r        <= r_rem;
          div_zero <= r_dz;
          done     <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_restoring_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_restoring_seq
// Brief    : Directed self-checking bench for div_restoring_seq (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_restoring_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       busy;
  logic       done;
  logic [7:0] q;
  logic [7:0] r;
  logic       div_zero;

  int n_run  = 0;
  int n_fail = 0;

  div_restoring_seq #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .busy     (busy),
    .done     (done),
    .q        (q),
    .r        (r),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits on falling edges until done is seen or the budget runs out.
  task automatic wait_done(input int max_cyc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < max_cyc);
  endtask

  initial begin
    int n;
    int extra;
    logic [7:0] ra, rb, eq, er;

    rst   = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;

    // Reset state
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", q, 0);
    chk("rst_r", r, 0);
    chk("rst_dz", div_zero, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // 0x45 / 0x07, cycle-exact latency and busy window
    a_in = 8'h45; b_in = 8'h07; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t1_busy_e0", busy, 1);
    chk("t1_done_e0", done, 0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk($sformatf("t1_done_e%0d", i), done, 0);
      chk($sformatf("t1_busy_e%0d", i), busy, 1);
    end
    @(negedge clk);
    chk("t1_done_e9", done, 1);
    chk("t1_busy_e9", busy, 1);
    chk("t1_q", q, 8'h09);
    chk("t1_r", r, 8'h06);
    chk("t1_dz", div_zero, 0);
    @(negedge clk);
    chk("t1_done_e10", done, 0);
    chk("t1_busy_e10", busy, 0);
    chk("t1_q_hold", q, 8'h09);

    // Back-to-back with start held high; operands changed after capture
    a_in = 8'hFF; b_in = 8'h01; start = 1'b1;
    @(negedge clk);
    a_in = 8'h05; b_in = 8'h09;
    wait_done(20, n);
    chk("t2_done1", done, 1);
    chk("t2_lat1", n, 9);
    chk("t2_q1", q, 8'hFF);
    chk("t2_r1", r, 8'h00);
    wait_done(20, n);
    start = 1'b0;
    chk("t2_done2", done, 1);
    chk("t2_gap", n, 10);
    chk("t2_q2", q, 8'h00);
    chk("t2_r2", r, 8'h05);
    @(negedge clk);
    chk("t2_busy_after", busy, 0);

    // Division by zero
    @(negedge clk);
    a_in = 8'h80; b_in = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(20, n);
    chk("t3_done", done, 1);
`ifdef DIV_ZERO_SHORTCUT_EN
    chk("t3_lat", n, 1);
`else
    chk("t3_lat", n, 9);
`endif
    chk("t3_q", q, 8'hFF);
    chk("t3_r", r, 8'h80);
    chk("t3_dz", div_zero, 1);
    @(negedge clk);

    // Start pulse during RUN is ignored
    a_in = 8'h64; b_in = 8'h0A; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    a_in = 8'h10; b_in = 8'h03; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(20, n);
    chk("t4_done", done, 1);
    chk("t4_lat", n, 5);
    chk("t4_q", q, 8'h0A);
    chk("t4_r", r, 8'h00);
    chk("t4_dz", div_zero, 0);
    extra = 0;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    chk("t4_extra_done", extra, 0);

    // Asynchronous reset in the middle of RUN
    a_in = 8'h45; b_in = 8'h07; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_q", q, 0);
    chk("t5_r", r, 0);
    @(negedge clk);
    rst = 1'b1;
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    chk("t5_no_done", extra, 0);
    a_in = 8'h45; b_in = 8'h07; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(20, n);
    chk("t5_done_after", done, 1);
    chk("t5_q_after", q, 8'h09);
    chk("t5_r_after", r, 8'h06);
    @(negedge clk);

    // Random non-zero divisors
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(1, 255));
      eq = ra / rb;
      er = ra % rb;
      a_in = ra; b_in = rb; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(20, n);
      chk($sformatf("rnd%0d_done a=%0h b=%0h", i, ra, rb), done, 1);
      chk($sformatf("rnd%0d_q a=%0h b=%0h", i, ra, rb), q, eq);
      chk($sformatf("rnd%0d_r a=%0h b=%0h", i, ra, rb), r, er);
      @(negedge clk);
      chk($sformatf("rnd%0d_pulse", i), done, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
